syscall_disp_hist: RTL and testbench
====================================

Name: syscall_disp_hist

Overview:
Parametrised syscall display unit for the pipelined CPU's FPGA top level. Captures the print-syscall argument (RF_B) whenever a qualified syscall retires with RF_A != EXIT_CODE, and keeps a DEPTH-entry history ring of printed values. Detects the exit syscall as a sticky halt, counts print events, and drives a time-multiplexed hex digit scan for the board display. Sits between the register-file read ports and the board display driver.

Parameters:
DATA_W, 32, width of RF_A/RF_B and displayed value; multiple of 4.
DEPTH, 8, history ring entries; power of two, >= 2.
EXIT_CODE, 32'd10, RF_A value that denotes the exit syscall.
SCAN_DIV, 50000, clk cycles per digit in the display scan; >= 2.
CNT_W, 16, width of the print-event counter.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
syscall  in  1  syscall instruction in the capture stage.
syscall_valid  in  1  stage valid: not stalled and not flushed; events need syscall & syscall_valid.
RF_A  in  DATA_W  syscall code register value.
RF_B  in  DATA_W  syscall argument register value.
clear  in  1  synchronous clear of history, counter and halt.
hist_mode  in  1  0 = live view, 1 = history view.
sel  in  clog2(DEPTH)  history index; 0 = newest.
syscallout  out  DATA_W  displayed value.
halted  out  1  sticky exit-syscall flag.
print_cnt  out  CNT_W  number of accepted print events, saturating.
fill  out  clog2(DEPTH)+1  valid history entries, saturates at DEPTH.
digit_an  out  DATA_W/4  one-hot active-low digit enable.
digit_val  out  4  hex nibble for the enabled digit.

Behaviour:
- Reset (rst=0, async): ring contents, wr_ptr, fill, print_cnt, halted and scan counter/index all 0. digit_an = all ones except bit0 = 0. syscallout = 0.
- ev = syscall & syscall_valid & ~halted.
- Print event: ev & (RF_A != EXIT_CODE). At the clock edge:
  - ring[wr_ptr] <= RF_B.
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - fill <= min(fill+1, DEPTH).
  - print_cnt <= print_cnt+1, saturating at all-ones.
- Exit event: ev & (RF_A == EXIT_CODE). halted <= 1. No ring write, no count.
- While halted=1, all syscalls are ignored until reset or clear.
- syscall without syscall_valid is ignored entirely (stall/flush bubble).
- clear=1 (synchronous): wr_ptr, fill, print_cnt and halted <= 0. Ring data is not required to be zeroed; fill=0 masks it.
- clear has priority over a same-cycle event; the event is dropped.
- syscallout is combinational from registers and inputs:
  - hist_mode=0: if a print event is present this cycle, syscallout = RF_B (same-cycle bypass). Otherwise ring[wr_ptr-1] when fill>0, else 0.
  - hist_mode=1: if sel < fill, ring[(wr_ptr-1-sel) mod DEPTH]; else 0. No bypass in this mode.
- Ring wrap: after DEPTH+k prints, the oldest k values are overwritten. sel=DEPTH-1 returns the (DEPTH)th-newest value.
- Scan:
  - Counter runs 0..SCAN_DIV-1 continuously and is not affected by clear or halted.
  - On wrap, digit index advances, modulo DATA_W/4.
  - digit_an[idx]=0, all other bits 1.
  - digit_val = syscallout[4*idx+3 : 4*idx], sampled combinationally.
- Asserting reset mid-operation immediately forces all reset values, independent of clk.

Test Plan:
- Reset then three print events (RF_A=1; RF_B=0x11, 0x22, 0x33) -> fill=3, print_cnt=3. Live syscallout=0x33. hist_mode=1: sel=0/1/2 give 0x33/0x22/0x11; sel=3 gives 0.
- syscall=1, syscall_valid=0, RF_B=0xAA -> no change to fill, count or syscallout. Same cycle with syscall_valid=1 -> syscallout=0xAA combinationally, before the edge.
- Ten prints (RF_B=1..10) with DEPTH=8 -> fill=8, print_cnt=10. hist_mode=1: sel=0 gives 10, sel=7 gives 3.
- RF_A=10 syscall -> halted=1. A following print with RF_B=0x55 is ignored (count unchanged). clear -> halted=0, fill=0, syscallout=0. Clear coinciding with a print -> print dropped.
- Scan with SCAN_DIV=4 and syscallout=0x12345678 -> every 4 cycles digit_an steps 0xFE, 0xFD, ... with digit_val 8, 7, ..., 1, then wraps.
- rst=0 asserted mid-scan with fill=5 and halted=1 -> all outputs return to reset values without a clock edge. print_cnt with CNT_W=2 saturates at 3 after 5 prints.

Source files
------------

// File: rtl/syscall_disp_hist.sv
// rtl/syscall_disp_hist.sv - syscall print capture with history ring, halt flag and hex digit scan
module syscall_disp_hist #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 8,
    parameter logic [31:0] EXIT_CODE = 32'd10,
    parameter int          SCAN_DIV  = 50000,
    parameter int          CNT_W     = 16,
    localparam int         PTR_W     = $clog2(DEPTH),
    localparam int         NDIG      = DATA_W / 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                syscall,
    input  logic                syscall_valid,
    input  logic [DATA_W-1:0]   RF_A,
    input  logic [DATA_W-1:0]   RF_B,
    input  logic                clear,
    input  logic                hist_mode,
    input  logic [PTR_W-1:0]    sel,
    output logic [DATA_W-1:0]   syscallout,
    output logic                halted,
    output logic [CNT_W-1:0]    print_cnt,
    output logic [PTR_W:0]      fill,
    output logic [NDIG-1:0]     digit_an,
    output logic [3:0]          digit_val
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int SC_W  = $clog2(SCAN_DIV);

    logic [DATA_W-1:0] ring [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [SC_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]  scan_idx;

    logic              ev;
    logic              is_exit;
    logic              print_ev;
    logic              exit_ev;
    logic [PTR_W-1:0]  newest_idx;
    logic [PTR_W-1:0]  hist_idx;

    assign ev       = syscall & syscall_valid & ~halted;
    assign is_exit  = (RF_A == DATA_W'(EXIT_CODE));
    assign print_ev = ev & ~is_exit;
    assign exit_ev  = ev & is_exit;

    // Pointer arithmetic relies on DEPTH being a power of two for natural wrap.
    assign newest_idx = wr_ptr - PTR_W'(1);
    assign hist_idx   = wr_ptr - PTR_W'(1) - sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring[i] <= '0;
            end
            wr_ptr    <= '0;
            fill      <= '0;
            print_cnt <= '0;
            halted    <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            fill      <= '0;
            print_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            if (print_ev) begin
                ring[wr_ptr] <= RF_B;
                wr_ptr       <= wr_ptr + PTR_W'(1);
                if (fill != (PTR_W+1)'(DEPTH)) begin
                    fill <= fill + (PTR_W+1)'(1);
                end
                if (print_cnt != {CNT_W{1'b1}}) begin
                    print_cnt <= print_cnt + CNT_W'(1);
                end
            end
            if (exit_ev) begin
                halted <= 1'b1;
            end
        end
    end

    always_comb begin
        syscallout = '0;
        if (!hist_mode) begin
            if (print_ev) begin
                syscallout = RF_B;
            end else if (fill != '0) begin
                syscallout = ring[newest_idx];
            end
        end else if ({1'b0, sel} < fill) begin
            syscallout = ring[hist_idx];
        end
    end

    // Free-running scan, deliberately independent of clear and halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (scan_idx == IDX_W'(NDIG - 1)) begin
                scan_idx <= '0;
            end else begin
                scan_idx <= scan_idx + IDX_W'(1);
            end
        end else begin
            scan_cnt <= scan_cnt + SC_W'(1);
        end
    end

    always_comb begin
        digit_an  = '1;
        digit_val = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                digit_an[i] = 1'b0;
                digit_val   = syscallout[4*i +: 4];
            end
        end
    end

endmodule

// File: tb/tb_syscall_disp_hist.sv
// tb/tb_syscall_disp_hist.sv - directed table-driven bench for syscall_disp_hist
module tb_syscall_disp_hist;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        syscall = 1'b0;
    logic        syscall_valid = 1'b0;
    logic [31:0] RF_A = '0;
    logic [31:0] RF_B = '0;
    logic        clear = 1'b0;
    logic        hist_mode = 1'b0;
    logic [2:0]  sel = '0;
    logic [31:0] syscallout;
    logic        halted;
    logic [15:0] print_cnt;
    logic [3:0]  fill;
    logic [7:0]  digit_an;
    logic [3:0]  digit_val;

    logic [31:0] syscallout2;
    logic        halted2;
    logic [1:0]  print_cnt2;
    logic [3:0]  fill2;
    logic [7:0]  digit_an2;
    logic [3:0]  digit_val2;

    int tests = 0;
    int fails = 0;
    int edges;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    syscall_disp_hist #(.DATA_W(32), .DEPTH(8), .EXIT_CODE(32'd10), .SCAN_DIV(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .syscall(syscall), .syscall_valid(syscall_valid),
        .RF_A(RF_A), .RF_B(RF_B), .clear(clear), .hist_mode(hist_mode), .sel(sel),
        .syscallout(syscallout), .halted(halted), .print_cnt(print_cnt), .fill(fill),
        .digit_an(digit_an), .digit_val(digit_val)
    );

    syscall_disp_hist #(.DATA_W(32), .DEPTH(8), .EXIT_CODE(32'd10), .SCAN_DIV(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .syscall(syscall), .syscall_valid(syscall_valid),
        .RF_A(RF_A), .RF_B(RF_B), .clear(clear), .hist_mode(hist_mode), .sel(sel),
        .syscallout(syscallout2), .halted(halted2), .print_cnt(print_cnt2), .fill(fill2),
        .digit_an(digit_an2), .digit_val(digit_val2)
    );

    typedef struct {
        logic        sc;
        logic        vld;
        logic        clr;
        logic        hm;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic [3:0]  fill;
        logic [15:0] cnt;
        logic        halt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic sc, logic vld, logic clr, logic hm, logic [2:0] s,
                                logic [31:0] a, logic [31:0] b, logic [31:0] out,
                                logic [3:0] f, logic [15:0] c, logic h);
        vec_t v;
        v.sc = sc; v.vld = vld; v.clr = clr; v.hm = hm; v.sel = s;
        v.a = a; v.b = b; v.out = out; v.fill = f; v.cnt = c; v.halt = h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sc, input logic vld, input logic clr, input logic hm,
                         input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        syscall = sc; syscall_valid = vld; clear = clr; hist_mode = hm; sel = s;
        RF_A = a; RF_B = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_out", syscallout, 32'h0);
        chk("rst_fill", 32'(fill), 32'h0);
        chk("rst_cnt", 32'(print_cnt), 32'h0);
        chk("rst_halt", 32'(halted), 32'h0);
        chk("rst_an", 32'(digit_an), 32'hFE);
        chk("rst_val", 32'(digit_val), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0,       0,       0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1,  32'h11,  32'h11,  1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1,  32'h22,  32'h22,  2, 2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1,  32'h33,  32'h33,  3, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0,       32'h33,  3, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0,       32'h33,  3, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,  0,       32'h22,  3, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2, 0,  0,       32'h11,  3, 3, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0,  0,       32'h0,   3, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1,  32'hAA,  32'h33,  3, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1,  32'hAA,  32'hAA,  4, 4, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 1,  32'hBB,  32'hAA,  5, 5, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 10, 32'h77,  32'hBB,  5, 5, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1,  32'h55,  32'hBB,  5, 5, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0,       32'hBB,  0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0,       32'h0,   0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 1,  32'h66,  32'h0,   0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0,       32'h0,   0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            vecs.push_back(mk(1, 1, 0, 0, 0, 1, 32'(k), 32'(k), (k > 8) ? 4'd8 : 4'(k), 16'(k), 0));
        end
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0,       32'd10,  8, 10, 0));
        vecs.push_back(mk(0, 0, 0, 1, 7, 0,  0,       32'd3,   8, 10, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0,  0,       32'd7,   8, 10, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0,       32'd10,  8, 10, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].sc, vecs[i].vld, vecs[i].clr, vecs[i].hm, vecs[i].sel, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("v%0d_out", i), syscallout, vecs[i].out);
            step();
            chk($sformatf("v%0d_fill", i), 32'(fill), 32'(vecs[i].fill));
            chk($sformatf("v%0d_cnt", i), 32'(print_cnt), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_cnt2", i), 32'(print_cnt2), (vecs[i].cnt > 3) ? 32'd3 : 32'(vecs[i].cnt));
            chk($sformatf("v%0d_halt", i), 32'(halted), 32'(vecs[i].halt));
        end

        // Scan: re-align the scan with a reset, then display a fixed value
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        drive(1, 1, 0, 0, 0, 1, 32'h12345678);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("scan_out", syscallout, 32'h12345678);
        for (int n = 0; n < 40; n++) begin
            int idx;
            logic [31:0] shv;
            logic [7:0]  an_exp;
            idx    = (edges / 4) % 8;
            shv    = 32'h12345678 >> (4 * idx);
            an_exp = ~(8'h01 << idx);
            chk($sformatf("scan%0d_an", n), 32'(digit_an), 32'(an_exp));
            chk($sformatf("scan%0d_val", n), 32'(digit_val), 32'(shv[3:0]));
            step();
        end

        // Async reset mid-operation with fill=5, halted=1; CNT_W=2 saturation
        drive(0, 0, 1, 0, 0, 0, 0);
        step();
        for (int k = 1; k <= 5; k++) begin
            drive(1, 1, 0, 0, 0, 1, 32'(k * 16 + 5));
            step();
        end
        drive(1, 1, 0, 0, 0, 10, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("pre_fill", 32'(fill), 32'd5);
        chk("pre_halt", 32'(halted), 32'd1);
        chk("pre_cnt", 32'(print_cnt), 32'd5);
        chk("sat_cnt2", 32'(print_cnt2), 32'd3);
        chk("pre_out", syscallout, 32'h55);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out", syscallout, 32'h0);
        chk("arst_fill", 32'(fill), 32'h0);
        chk("arst_cnt", 32'(print_cnt), 32'h0);
        chk("arst_cnt2", 32'(print_cnt2), 32'h0);
        chk("arst_halt", 32'(halted), 32'h0);
        chk("arst_an", 32'(digit_an), 32'hFE);
        chk("arst_val", 32'(digit_val), 32'h0);
        #10;
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
